// File: rtl/bank_isu_dispatch.sv
// bank_isu_dispatch: pops the issue-queue head and drives bank data-array beats, critical beat first.
// Each request then produces one completion response to the requesting channel.
//   clk_i, rst_i                 clock; asynchronous active-high reset
//   head_*_i, head_ready_o       issue-queue head entry and pop strobe
//   arr_*_o, arr_ready_i         per-beat data-array access handshake
//   resp_*_o, resp_ready_i       completion response handshake
module bank_isu_dispatch #(
    parameter int BEAT_W = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       head_valid_i,
    output logic       head_ready_o,
    input  logic [2:0] head_rob_id_i,
    input  logic [1:0] head_ch_id_i,
    input  logic [1:0] head_opcode_i,
    input  logic [6:0] head_set_way_offset_i,
    input  logic [7:0] head_wbuffer_id_i,
    input  logic [3:0] head_cacheline_state_i,
    output logic       arr_valid_o,
    input  logic       arr_ready_i,
    output logic       arr_we_o,
    output logic [6:0] arr_addr_o,
    output logic [7:0] arr_wbuffer_id_o,
    output logic       resp_valid_o,
    input  logic       resp_ready_i,
    output logic [2:0] resp_rob_id_o,
    output logic [1:0] resp_ch_id_o,
    output logic [1:0] resp_opcode_o,
    output logic       resp_miss_o,
    output logic       resp_dirty_o
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_FLUSH = 2'd2;
    localparam logic [1:0] OP_STATE = 2'd3;
    state_t            state_q, state_d;
    logic [2:0]        rob_q, rob_d;
    logic [1:0]        ch_q, ch_d;
    logic [1:0]        op_q, op_d;
    logic [6:0]        swo_q, swo_d;
    logic [7:0]        wb_q, wb_d;
    logic [1:0]        st_q, st_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [BEAT_W-1:0] beat_addr;
    logic              unused_state;
    assign unused_state = ^head_cacheline_state_i[3:2];
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rob_q   <= '0;
            ch_q    <= '0;
            op_q    <= '0;
            swo_q   <= '0;
            wb_q    <= '0;
            st_q    <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            rob_q   <= rob_d;
            ch_q    <= ch_d;
            op_q    <= op_d;
            swo_q   <= swo_d;
            wb_q    <= wb_d;
            st_q    <= st_d;
            beat_q  <= beat_d;
        end
    end
    always_comb begin
        state_d = state_q;
        rob_d   = rob_q;
        ch_d    = ch_q;
        op_d    = op_q;
        swo_d   = swo_q;
        wb_d    = wb_q;
        st_d    = st_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: if (head_valid_i) begin
                rob_d   = head_rob_id_i;
                ch_d    = head_ch_id_i;
                op_d    = head_opcode_i;
                swo_d   = head_set_way_offset_i;
                wb_d    = head_wbuffer_id_i;
                st_d    = head_cacheline_state_i[1:0];
                beat_d  = '0;
                // READ and FLUSH (opcode bit0 clear) to an invalid line skip the array
                state_d = (head_opcode_i == OP_STATE ||
                           (!head_opcode_i[0] && !head_cacheline_state_i[0])) ? RESP : ACCESS;
            end
            ACCESS: if (arr_ready_i) begin
                beat_d  = beat_q + 1'b1;
                state_d = &beat_q ? RESP : ACCESS;
            end
            RESP: state_d = resp_ready_i ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    // offset plus beat count wraps within the line: critical beat first
    assign beat_addr        = swo_q[BEAT_W-1:0] + beat_q;
    assign arr_addr_o       = {swo_q[6:BEAT_W], beat_addr};
    assign arr_valid_o      = state_q == ACCESS;
    assign arr_we_o         = arr_valid_o && op_q == OP_WRITE;
    assign arr_wbuffer_id_o = wb_q;
    assign head_ready_o     = state_q == IDLE && !rst_i;
    assign resp_valid_o     = state_q == RESP;
    assign resp_rob_id_o    = rob_q;
    assign resp_ch_id_o     = ch_q;
    assign resp_opcode_o    = op_q;
    assign resp_miss_o      = resp_valid_o && !op_q[0] && !st_q[0];
    assign resp_dirty_o     = resp_valid_o && op_q == OP_FLUSH && st_q == 2'b11;
endmodule

// File: tb/tb_bank_isu_dispatch.sv
// tb_bank_isu_dispatch: directed and randomized requests checked against a request-level model.
module tb_bank_isu_dispatch;
    logic       clk = 0;
    logic       rst_i = 1;
    logic       head_valid_i = 0;
    logic       head_ready_o;
    logic [2:0] head_rob_id_i = 0;
    logic [1:0] head_ch_id_i = 0;
    logic [1:0] head_opcode_i = 0;
    logic [6:0] head_set_way_offset_i = 0;
    logic [7:0] head_wbuffer_id_i = 0;
    logic [3:0] head_cacheline_state_i = 0;
    logic       arr_valid_o;
    logic       arr_ready_i = 0;
    logic       arr_we_o;
    logic [6:0] arr_addr_o;
    logic [7:0] arr_wbuffer_id_o;
    logic       resp_valid_o;
    logic       resp_ready_i = 0;
    logic [2:0] resp_rob_id_o;
    logic [1:0] resp_ch_id_o;
    logic [1:0] resp_opcode_o;
    logic       resp_miss_o;
    logic       resp_dirty_o;
    int errors = 0;
    int checks = 0;

    bank_isu_dispatch #(.BEAT_W(2)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .head_valid_i(head_valid_i), .head_ready_o(head_ready_o),
        .head_rob_id_i(head_rob_id_i), .head_ch_id_i(head_ch_id_i),
        .head_opcode_i(head_opcode_i), .head_set_way_offset_i(head_set_way_offset_i),
        .head_wbuffer_id_i(head_wbuffer_id_i), .head_cacheline_state_i(head_cacheline_state_i),
        .arr_valid_o(arr_valid_o), .arr_ready_i(arr_ready_i), .arr_we_o(arr_we_o),
        .arr_addr_o(arr_addr_o), .arr_wbuffer_id_o(arr_wbuffer_id_o),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_rob_id_o(resp_rob_id_o), .resp_ch_id_o(resp_ch_id_o),
        .resp_opcode_o(resp_opcode_o), .resp_miss_o(resp_miss_o), .resp_dirty_o(resp_dirty_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_arr_valid"}, arr_valid_o, 0);
        chk({tag, "_resp_valid"}, resp_valid_o, 0);
        chk({tag, "_we"}, arr_we_o, 0);
        chk({tag, "_miss"}, resp_miss_o, 0);
        chk({tag, "_dirty"}, resp_dirty_o, 0);
    endtask

    // rdy_mode: 0 = array always ready, 1 = random ready, 2 = pattern 1,0,0,1,1,1
    task automatic do_req(input logic [1:0] op, input logic [6:0] swo, input logic [7:0] wb,
                          input logic [3:0] st, input logic [2:0] rob, input logic [1:0] ch,
                          input int rdy_mode, input int resp_wait);
        bit pat [6] = '{1, 0, 0, 1, 1, 1};
        bit miss, dirty, rdy;
        int nbeats, k, cyc;
        miss   = (op == 0 || op == 2) && !st[0];
        dirty  = op == 2 && st[0] && st[1];
        nbeats = (op == 3 || miss) ? 0 : 4;
        chk("idle_head_ready", head_ready_o, 1);
        head_valid_i = 1;
        head_opcode_i = op;
        head_set_way_offset_i = swo;
        head_wbuffer_id_i = wb;
        head_cacheline_state_i = st;
        head_rob_id_i = rob;
        head_ch_id_i = ch;
        @(negedge clk);
        head_valid_i = 0;
        head_opcode_i = 2'($urandom);
        head_set_way_offset_i = 7'($urandom);
        head_cacheline_state_i = 4'($urandom);
        k = 0;
        cyc = 0;
        while (k < nbeats && cyc < 64) begin
            chk("beat_valid", arr_valid_o, 1);
            chk("beat_resp_valid", resp_valid_o, 0);
            chk("beat_head_ready", head_ready_o, 0);
            chk("beat_we", arr_we_o, op == 1);
            chk("beat_addr", arr_addr_o, (swo & 7'h7C) | ((swo + k) % 4));
            chk("beat_wbid", arr_wbuffer_id_o, wb);
            rdy = rdy_mode == 0 ? 1 : rdy_mode == 1 ? bit'($urandom_range(0, 1)) :
                  (cyc < 6 ? pat[cyc] : 1);
            arr_ready_i = rdy;
            @(negedge clk);
            if (rdy) k++;
            cyc++;
        end
        if (cyc >= 64) chk("beat_timeout", 0, 1);
        arr_ready_i = bit'($urandom_range(0, 1));
        head_valid_i = 1;
        for (int w = 0; w <= resp_wait; w++) begin
            chk("resp_valid", resp_valid_o, 1);
            chk("resp_arr_valid", arr_valid_o, 0);
            chk("resp_head_ready", head_ready_o, 0);
            chk("resp_rob", resp_rob_id_o, rob);
            chk("resp_ch", resp_ch_id_o, ch);
            chk("resp_op", resp_opcode_o, op);
            chk("resp_miss", resp_miss_o, miss);
            chk("resp_dirty", resp_dirty_o, dirty);
            resp_ready_i = w == resp_wait;
            @(negedge clk);
        end
        resp_ready_i = 0;
        head_valid_i = 0;
        chk("post_resp_valid", resp_valid_o, 0);
        chk("post_arr_valid", arr_valid_o, 0);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_head_ready", head_ready_o, 0);
        chk_quiet("rst");
        chk("rst_rob", resp_rob_id_o, 0);
        chk("rst_wbid", arr_wbuffer_id_o, 0);
        rst_i = 0;
        #1;
        chk("rel_head_ready", head_ready_o, 1);
        head_valid_i = 0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_head_ready", head_ready_o, 1);
            chk_quiet("idle");
        end
        do_req(2'd0, 7'h26, 8'h11, 4'b0001, 3'd5, 2'd2, 0, 0);
        do_req(2'd1, 7'h13, 8'hA5, 4'b0000, 3'd3, 2'd1, 0, 0);
        do_req(2'd0, 7'h40, 8'h22, 4'b0000, 3'd1, 2'd3, 0, 0);
        do_req(2'd3, 7'h55, 8'h33, 4'b0010, 3'd6, 2'd0, 0, 0);
        do_req(2'd2, 7'h2A, 8'h44, 4'b0011, 3'd2, 2'd1, 2, 0);
        do_req(2'd2, 7'h0B, 8'h45, 4'b0000, 3'd4, 2'd2, 0, 0);
        do_req(2'd0, 7'h31, 8'h66, 4'b0011, 3'd7, 2'd0, 0, 5);
        // reset during the second beat discards the request
        chk("mid_head_ready", head_ready_o, 1);
        head_valid_i = 1;
        head_opcode_i = 0;
        head_set_way_offset_i = 7'h05;
        head_cacheline_state_i = 4'b0001;
        arr_ready_i = 1;
        @(negedge clk);
        head_valid_i = 0;
        @(negedge clk);
        chk("mid_beat2_valid", arr_valid_o, 1);
        chk("mid_beat2_addr", arr_addr_o, 7'h06);
        #1 rst_i = 1;
        #1;
        chk("mid_rst_head_ready", head_ready_o, 0);
        chk_quiet("mid_rst");
        @(negedge clk);
        rst_i = 0;
        #1;
        chk("mid_rel_head_ready", head_ready_o, 1);
        repeat (6) begin
            @(negedge clk);
            chk_quiet("mid_after");
            chk("mid_after_head_ready", head_ready_o, 1);
        end
        for (int i = 0; i < 40; i++)
            do_req(2'($urandom), 7'($urandom), 8'($urandom), 4'($urandom), 3'($urandom),
                   2'($urandom), 1, int'($urandom_range(0, 3)));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
